// File: rtl/tetris_pkg.sv
// tetris_pkg: shared FSM state codes, internal engine states, board size
// defaults, the 4x4 shape table and the clockwise box rotation helper.
package tetris_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 8;

    // Codes driven by the main game FSM
    localparam logic [2:0] FSM_GEN      = 3'b000;
    localparam logic [2:0] FSM_MOVE     = 3'b001;
    localparam logic [2:0] FSM_LAND     = 3'b010;
    localparam logic [2:0] FSM_CLEAR    = 3'b011;
    localparam logic [2:0] FSM_NEWBOARD = 3'b100;
    localparam logic [2:0] FSM_GAMEOVER = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        MERGE  = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4,
        OVER   = 3'd5
    } engine_state_t;

    // Shape masks: bit 4*br+bc, box row br, box column bc
    localparam logic [15:0] SHAPE_I = 16'h000F;
    localparam logic [15:0] SHAPE_O = 16'h0033;
    localparam logic [15:0] SHAPE_T = 16'h0027;
    localparam logic [15:0] SHAPE_S = 16'h0036;
    localparam logic [15:0] SHAPE_Z = 16'h0063;
    localparam logic [15:0] SHAPE_J = 16'h0071;
    localparam logic [15:0] SHAPE_L = 16'h0074;

    // Seven-entry shape ROM; code 7 falls back to the O piece
    function automatic logic [15:0] shape_mask(input logic [2:0] id);
        logic [15:0] m;
        case (id)
            3'd0:    m = SHAPE_I;
            3'd1:    m = SHAPE_O;
            3'd2:    m = SHAPE_T;
            3'd3:    m = SHAPE_S;
            3'd4:    m = SHAPE_Z;
            3'd5:    m = SHAPE_J;
            3'd6:    m = SHAPE_L;
            default: m = SHAPE_O;
        endcase
        return m;
    endfunction

    // Clockwise rotation inside the 4x4 box: new(br,bc) = old(3-bc, br)
    function automatic logic [15:0] rotate_cw(input logic [15:0] m);
        logic [15:0] r;
        r = '0;
        for (int br = 0; br < 4; br++) begin
            for (int bc = 0; bc < 4; bc++) begin
                r[4*br+bc] = m[4*(3-bc)+br];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piece_collide.sv
// piece_collide: combinational collision test of a 4x4 candidate piece
// against the walls, the floor and the landed board.
module piece_collide #(
    parameter int ROWS = 16,
    parameter int COLS = 8,
    parameter int RW   = 6,
    parameter int CW   = 5
) (
    input  logic [ROWS-1:0][COLS-1:0] board,
    input  logic [15:0]               mask,
    input  logic signed [RW-1:0]      origin_row,
    input  logic signed [CW-1:0]      origin_col,
    output logic                      hit
);

    localparam int RIDX = $clog2(ROWS);
    localparam int CIDX = $clog2(COLS);

    logic [15:0] cell_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cell
            logic signed [RW-1:0] cell_row;
            logic signed [CW-1:0] cell_col;
            logic                 in_bounds;
            logic                 occupied;

            assign cell_row  = origin_row + $signed(RW'(gi / 4));
            assign cell_col  = origin_col + $signed(CW'(gi % 4));
            // Rows never go negative, but keep the sign test for safety
            assign in_bounds = !cell_row[RW-1] && (cell_row < $signed(RW'(ROWS))) &&
                               !cell_col[CW-1] && (cell_col < $signed(CW'(COLS)));
            // Board lookup is only meaningful when in_bounds holds
            assign occupied  = board[cell_row[RIDX-1:0]][cell_col[CIDX-1:0]];
            assign cell_hit[gi] = mask[gi] && (!in_bounds || occupied);
        end
    endgenerate

    assign hit = |cell_hit;

endmodule

// File: rtl/piece_engine.sv
// piece_engine: responder to the main game FSM. Owns the landed board and
// the falling piece, merges it on landing, collapses full rows and reports
// placed / game_over. Optional rotation is enabled by PIECE_ROTATE_EN.
module piece_engine
    import tetris_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int SPAWN_COL = 2
) (
    input  logic                    clka,
    input  logic                    restart,
    input  logic [2:0]              fsm_state,
    input  logic [2:0]              piece_id,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_rot,
    input  logic                    drop_tick,
    output logic                    placed,
    output logic                    game_over,
    output logic [7:0]              lines_total,
    input  logic [$clog2(ROWS)-1:0] row_sel,
    output logic [COLS-1:0]         row_data
);

    localparam int RIDX = $clog2(ROWS);
    localparam int CIDX = $clog2(COLS);
    localparam int RW   = RIDX + 2;
    localparam int CW   = CIDX + 2;

    engine_state_t            state_reg;
    logic [ROWS-1:0][COLS-1:0] board_reg;
    logic [15:0]              mask_reg;
    logic signed [RW-1:0]     orow_reg;
    logic signed [CW-1:0]     ocol_reg;
    logic [RIDX-1:0]          scan_reg;
    logic                     placed_reg;
    logic                     game_over_reg;
    logic [7:0]               lines_reg;

`ifdef PIECE_ROTATE_EN
    logic [1:0]               rot_count_reg;
`else
    logic                     unused_rot;
    assign unused_rot = btn_rot;
`endif

    logic [15:0]               cand_mask;
    logic signed [RW-1:0]      cand_row;
    logic signed [CW-1:0]      cand_col;
    logic                      cand_hit;
    logic [ROWS-1:0][COLS-1:0] overlay;
    logic [ROWS-1:0][COLS-1:0] shifted;
    logic                      row_full;

    // Candidate mux: spawn position in IDLE, otherwise the highest-priority move
    always_comb begin
        cand_mask = mask_reg;
        cand_row  = orow_reg;
        cand_col  = ocol_reg;
        if (state_reg == IDLE) begin
            cand_mask = shape_mask(piece_id);
            cand_row  = '0;
            cand_col  = CW'(SPAWN_COL);
        end else if (drop_tick) begin
            cand_row = orow_reg + RW'(1);
        end
`ifdef PIECE_ROTATE_EN
        else if (btn_rot) begin
            cand_mask = rotate_cw(mask_reg);
        end
`endif
        else if (btn_left) begin
            cand_col = ocol_reg - CW'(1);
        end else if (btn_right) begin
            cand_col = ocol_reg + CW'(1);
        end
    end

    piece_collide #(
        .ROWS(ROWS),
        .COLS(COLS),
        .RW  (RW),
        .CW  (CW)
    ) u_collide (
        .board     (board_reg),
        .mask      (cand_mask),
        .origin_row(cand_row),
        .origin_col(cand_col),
        .hit       (cand_hit)
    );

    genvar gi, gj;
    generate
        // Board-sized image of the active piece, used for merge and display
        for (gi = 0; gi < ROWS; gi++) begin : g_ovl_row
            for (gj = 0; gj < COLS; gj++) begin : g_ovl_col
                logic signed [RW-1:0] dr;
                logic signed [CW-1:0] dc;
                assign dr = $signed(RW'(gi)) - orow_reg;
                assign dc = $signed(CW'(gj)) - ocol_reg;
                assign overlay[gi][gj] = !dr[RW-1] && (dr[RW-2:2] == '0) &&
                                         !dc[CW-1] && (dc[CW-2:2] == '0) &&
                                         mask_reg[{dr[1:0], dc[1:0]}];
            end
        end

        // Board with rows 0..scan shifted down one and row 0 emptied
        for (gi = 0; gi < ROWS; gi++) begin : g_shift
            if (gi == 0) begin : g_top
                assign shifted[gi] = '0;
            end else begin : g_rest
                assign shifted[gi] = (RIDX'(gi) <= scan_reg) ? board_reg[gi-1] : board_reg[gi];
            end
        end
    endgenerate

    assign row_full = &board_reg[scan_reg];

    // Engine FSM: spawn, move, merge, row collapse and handshake outputs
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_reg     <= IDLE;
            board_reg     <= '0;
            mask_reg      <= '0;
            orow_reg      <= '0;
            ocol_reg      <= '0;
            scan_reg      <= '0;
            placed_reg    <= 1'b0;
            game_over_reg <= 1'b0;
            lines_reg     <= '0;
`ifdef PIECE_ROTATE_EN
            rot_count_reg <= '0;
`endif
        end else if (fsm_state == FSM_NEWBOARD) begin
            state_reg     <= IDLE;
            board_reg     <= '0;
            placed_reg    <= 1'b0;
            game_over_reg <= 1'b0;
            lines_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fsm_state == FSM_GEN) begin
                        mask_reg <= cand_mask;
                        orow_reg <= '0;
                        ocol_reg <= CW'(SPAWN_COL);
`ifdef PIECE_ROTATE_EN
                        rot_count_reg <= '0;
`endif
                        if (cand_hit) begin
                            game_over_reg <= 1'b1;
                            state_reg     <= OVER;
                        end else begin
                            state_reg <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (fsm_state == FSM_MOVE) begin
                        if (drop_tick) begin
                            if (!cand_hit) orow_reg <= cand_row;
                            else           state_reg <= MERGE;
                        end
`ifdef PIECE_ROTATE_EN
                        else if (btn_rot) begin
                            if (!cand_hit) begin
                                mask_reg      <= cand_mask;
                                rot_count_reg <= rot_count_reg + 2'd1;
                            end
                        end
`endif
                        else if (btn_left || btn_right) begin
                            if (!cand_hit) ocol_reg <= cand_col;
                        end
                    end
                end
                MERGE: begin
                    board_reg <= board_reg | overlay;
                    scan_reg  <= RIDX'(ROWS - 1);
                    state_reg <= SCAN;
                end
                SCAN: begin
                    if (row_full) begin
                        board_reg <= shifted;
                        lines_reg <= lines_reg + 8'd1;
                    end else if (scan_reg == '0) begin
                        placed_reg <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        scan_reg <= scan_reg - RIDX'(1);
                    end
                end
                DONE: begin
                    if (fsm_state != FSM_MOVE) begin
                        placed_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                OVER: begin
                    game_over_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign placed      = placed_reg;
    assign game_over   = game_over_reg;
    assign lines_total = lines_reg;
    assign row_data    = board_reg[row_sel] | ((state_reg == ACTIVE) ? overlay[row_sel] : '0);

endmodule

// File: doc/piece_engine.md
# piece_engine

Responder side of the main game-FSM handshake. Consumes the FSM's 3-bit state code and returns `placed` and `game_over`. Owns the landed-board bitmap and the active falling piece: spawns on GEN, moves and drops on MOVE, then merges the piece and collapses full rows before it reports `placed`. Also supplies per-row board data to the display path.

## Interface
- `ROWS`, 16, board height; row 0 is the top.
- `COLS`, 8, board width; column 0 is the left.
- `SPAWN_COL`, 2, column of the left edge of the 4x4 piece box at spawn.
- `clka`  in  1  single system clock; all state updates on posedge.
- `restart`  in  1  asynchronous, active-high reset.
- `fsm_state`  in  3  main FSM code: GEN=000, MOVE=001, LAND=010, CLEAR=011 (unused), NEWBOARD=100, GAMEOVER=101.
- `piece_id`  in  3  shape to spawn: 0..6 = I,O,T,S,Z,J,L; 7 is treated as O.
- `btn_left`, `btn_right`, `btn_rot`  in  1 each  single-cycle move requests.
- `drop_tick`  in  1  single-cycle gravity pulse.
- `placed`  out  1  level; piece landed and row collapse finished.
- `game_over`  out  1  level; the spawn position collided.
- `lines_total`  out  8  number of rows cleared since NEWBOARD; wraps modulo 256.
- `row_sel`  in  $clog2(ROWS)  display row select.
- `row_data`  out  COLS  combinational: board row OR active-piece cells for `row_sel` (piece cells only in ACTIVE).

## Operation
- Reset value of every output is 0. On reset, the board is cleared and the internal FSM goes to IDLE.
- Internal states: IDLE, ACTIVE, MERGE, SCAN, DONE, OVER.
- Any state, `fsm_state`==NEWBOARD: clear the board, `lines_total`, `placed` and `game_over`, then go to IDLE.
- IDLE, `fsm_state`==GEN: load the mask for `piece_id`, set origin to row 0 / `SPAWN_COL`, set rotation to 0.
  - If the spawn position collides: set `game_over`=1 and go to OVER.
  - Otherwise go to ACTIVE.
- ACTIVE, `fsm_state`==MOVE: at most one action per cycle. Priority is `drop_tick` > `btn_rot` > `btn_left` > `btn_right`; lower-priority requests in the same cycle are discarded.
  - Left/right/rotate: apply only if the candidate position has no collision; otherwise ignore.
  - Drop: move down one row if that is collision-free; otherwise go to MERGE.
- Collision means any piece cell has column <0, column >=COLS, or row >=ROWS, or the cell overlaps an occupied board cell.
- MERGE (1 cycle): OR the piece cells into the board. Set scan row r=ROWS-1, then go to SCAN.
- SCAN (1 row per cycle):
  - If row r is full: shift rows 0..r-1 down by one, clear row 0, increment `lines_total`, and keep the same r.
  - Otherwise: if r==0 go to DONE, else decrement r.
- DONE: `placed`=1. When `fsm_state` leaves MOVE: clear `placed` and go to IDLE.
- OVER: `game_over` is held at 1 until NEWBOARD or `restart`.
- Piece mask encoding: 16 bits, bit 4*br+bc, box row br and box column bc. Piece cells are at (origin_row+br, origin_col+bc).
- Origin column is signed, so a piece box may hang past the left wall while its cells stay in bounds.

## Timing
- `game_over` is registered: it is valid the cycle after the GEN cycle.
- A move request takes effect on the posedge where it is sampled; `row_data` reflects it the same cycle after that edge.
- Landing to `placed`: 1 (MERGE) + ROWS + k cycles, where k is the number of cleared rows (k<=4). That is 17..21 cycles with the default parameters.
- `placed` is never asserted while SCAN is in progress.
- `restart` mid-SCAN or mid-MERGE discards the in-flight work. The board returns to empty.
- A NEWBOARD code seen in ACTIVE or SCAN aborts that work the same way.

## Configuration
- `PIECE_ROTATE_EN` defined:
  - `btn_rot` rotates clockwise within the 4x4 box: new(br,bc) = old(3-bc, br).
  - The rotation count is a 2-bit value that wraps 3->0.
- `PIECE_ROTATE_EN` undefined:
  - `btn_rot` is ignored and does not block a same-cycle left/right request.
  - Rotation logic is not synthesized.

## Structure
- Shared package `tetris_pkg`:
  - FSM state-code constants.
  - 7-entry 16-bit shape ROM.
  - Internal state enum.
  - `ROWS`/`COLS` defaults.
- Sub-module `piece_collide`: combinational. Inputs are the board, a candidate mask, and an origin. Output is the collision flag. It is instantiated once and shared across spawn, move and drop via a candidate mux.

## Test plan
- Reset, NEWBOARD, GEN with `piece_id`=1 (O): `row_data` at `row_sel`=0 is 8'b00001100 (column 2 → bit 2). `game_over`=0.
- O piece in MOVE with 16 `drop_tick`: lands at rows 14-15. `placed` rises 17 cycles after the blocking tick. Rows 14/15 are 8'b00001100.
- Pre-fill row 15 to 8'b11110011, then drop O into it: row 15 clears and rows shift down. `lines_total`=1. `placed` after 18 cycles.
- `btn_left` ×3 with O at column 2: the third press is ignored and the piece stays at columns 0-1. `btn_left` with `drop_tick` in the same cycle: only the drop happens.
- Board rows 0-1 occupied at columns 2-3, then GEN: `game_over`=1 the next cycle and holds through MOVE codes. NEWBOARD clears it and `lines_total`.
- With `PIECE_ROTATE_EN`: I piece, `btn_rot` ×4 returns to the original mask. A rotation blocked by a wall is ignored. Without the macro, `btn_rot` has no effect.
